// File: rtl/disk_dma.sv
`timescale 1ns/1ps
// disk_dma: moves one 256-byte sector between 32-bit main memory and the disk
// byte-buffer window, then fires the disk send/fetch trigger.
module disk_dma #(
    parameter int unsigned DK_RD_WAIT = 3,
    parameter int unsigned POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        irq,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [8:0]  dk_addr,
    output logic        dk_read,
    output logic        dk_write,
    output logic [31:0] dk_wdata,
    input  logic [31:0] dk_rdata
);
    localparam int unsigned WAIT_W = (DK_RD_WAIT > 1) ? $clog2(DK_RD_WAIT) : 1;
    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DK_RD_WAIT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [8:0] A_SECT = 9'h100;
    localparam logic [8:0] A_DONE = 9'h101;
    localparam logic [8:0] A_TRIG = 9'h102;

    typedef enum logic [3:0] {
        IDLE, M_RD, D_WR, W_SECT, W_TRIG, R_SECT, R_TRIG, R_POLL, D_RD, M_WR, FIN
    } state_t;

    state_t             state_q;
    logic [31:0]        memaddr_q;
    logic [15:0]        sector_q;
    logic               dir_q, busy_q, done_q, err_q;
    logic [5:0]         word_q;
    logic [1:0]         byte_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [POLL_W-1:0]  poll_q;
    logic [31:0]        buf_q;
    logic               mem_req_q, mem_we_q, dk_read_q, dk_write_q;
    logic [31:0]        mem_addr_q, mem_wdata_q, dk_wdata_q;
    logic [8:0]         dk_addr_q;

    logic [5:0] word_nx;
    logic [1:0] byte_nx;
    logic [7:0] wr_byte;
    logic       rd_last, start, unused_dk_hi;

    assign word_nx      = word_q + 6'd1;
    assign byte_nx      = byte_q + 2'd1;
    assign wr_byte      = buf_q[{byte_nx, 3'b000} +: 8];
    assign rd_last      = (wait_q == WAIT_LAST);
    assign start        = cfg_we && (cfg_addr == 2'd2) && cfg_wdata[0] && !busy_q;
    assign unused_dk_hi = ^dk_rdata[31:16];

    assign irq       = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dk_addr   = dk_addr_q;
    assign dk_read   = dk_read_q;
    assign dk_write  = dk_write_q;
    assign dk_wdata  = dk_wdata_q;

    // Register read mux; start reads back as 0.
    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata = memaddr_q;
            2'd1:    cfg_rdata = {16'd0, sector_q};
            2'd2:    cfg_rdata = {30'd0, dir_q, 1'b0};
            default: cfg_rdata = {29'd0, err_q, done_q, busy_q};
        endcase
    end

    // Register bank plus transfer FSM; every bus output is set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            memaddr_q   <= 32'd0;
            sector_q    <= 16'd0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            word_q      <= 6'd0;
            byte_q      <= 2'd0;
            wait_q      <= '0;
            poll_q      <= '0;
            buf_q       <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            dk_read_q   <= 1'b0;
            dk_write_q  <= 1'b0;
            dk_addr_q   <= 9'd0;
            dk_wdata_q  <= 32'd0;
        end else begin
            if (cfg_we && !busy_q) begin
                case (cfg_addr)
                    2'd0:    memaddr_q <= cfg_wdata;
                    2'd1:    sector_q  <= cfg_wdata[15:0];
                    2'd2:    dir_q     <= cfg_wdata[1];
                    default: ;
                endcase
            end
            case (state_q)
                IDLE: if (start) begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    word_q <= 6'd0;
                    byte_q <= 2'd0;
                    wait_q <= '0;
                    poll_q <= '0;
                    if (cfg_wdata[1]) begin
                        state_q    <= M_RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= memaddr_q;
                    end else begin
                        state_q    <= R_SECT;
                        dk_write_q <= 1'b1;
                        dk_addr_q  <= A_SECT;
                        dk_wdata_q <= {16'd0, sector_q};
                    end
                end
                M_RD: if (mem_ack) begin
                    mem_req_q  <= 1'b0;
                    buf_q      <= mem_rdata;
                    state_q    <= D_WR;
                    dk_write_q <= 1'b1;
                    dk_addr_q  <= {1'b0, word_q, 2'd0};
                    dk_wdata_q <= {24'd0, mem_rdata[7:0]};
                end
                D_WR: begin
                    byte_q <= byte_nx;
                    if (byte_q != 2'd3) begin
                        dk_addr_q  <= {1'b0, word_q, byte_nx};
                        dk_wdata_q <= {24'd0, wr_byte};
                    end else if (word_q == 6'd63) begin
                        state_q    <= W_SECT;
                        dk_addr_q  <= A_SECT;
                        dk_wdata_q <= {16'd0, sector_q};
                    end else begin
                        state_q    <= M_RD;
                        dk_write_q <= 1'b0;
                        word_q     <= word_nx;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= memaddr_q + 32'(word_nx);
                    end
                end
                W_SECT: begin
                    state_q    <= W_TRIG;
                    dk_addr_q  <= A_TRIG;
                    dk_wdata_q <= 32'd0;
                end
                W_TRIG: begin
                    state_q    <= FIN;
                    dk_write_q <= 1'b0;
                end
                R_SECT: begin
                    state_q    <= R_TRIG;
                    dk_write_q <= 1'b0;
                    dk_read_q  <= 1'b1;
                    dk_addr_q  <= A_TRIG;
                end
                R_TRIG: begin
                    wait_q <= rd_last ? '0 : wait_q + WAIT_W'(1);
                    if (rd_last) begin
                        state_q   <= R_POLL;
                        dk_addr_q <= A_DONE;
                    end
                end
                R_POLL: begin
                    wait_q <= rd_last ? '0 : wait_q + WAIT_W'(1);
                    if (rd_last) begin
                        if (dk_rdata[15:0] == sector_q) begin
                            state_q   <= D_RD;
                            dk_addr_q <= 9'd0;
                        end else if (poll_q == POLL_LAST) begin
                            state_q   <= FIN;
                            dk_read_q <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            poll_q <= poll_q + POLL_W'(1);
                        end
                    end
                end
                D_RD: begin
                    wait_q <= rd_last ? '0 : wait_q + WAIT_W'(1);
                    if (rd_last) begin
                        buf_q[{byte_q, 3'b000} +: 8] <= dk_rdata[7:0];
                        byte_q <= byte_nx;
                        if (byte_q == 2'd3) begin
                            state_q     <= M_WR;
                            dk_read_q   <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= memaddr_q + 32'(word_q);
                            mem_wdata_q <= {dk_rdata[7:0], buf_q[23:0]};
                        end else begin
                            dk_addr_q <= {1'b0, word_q, byte_nx};
                        end
                    end
                end
                M_WR: if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (word_q == 6'd63) begin
                        state_q <= FIN;
                    end else begin
                        state_q   <= D_RD;
                        word_q    <= word_nx;
                        byte_q    <= 2'd0;
                        dk_read_q <= 1'b1;
                        dk_addr_q <= {1'b0, word_nx, 2'd0};
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
